// File: rtl/rover_pkg.sv
// Shared rover definitions: FSM state codes, bridge direction codes and small helpers.
// Used by the motor path and the rover top level.
package rover_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFwd   = 3'd1,
      StBrake = 3'd2,
      StRev   = 3'd3,
      StTurn  = 3'd4
   } state_e;

   // {IN4,IN3,IN2,IN1}
   localparam logic [3:0] DirStop = 4'b0000;
   localparam logic [3:0] DirFwd  = 4'b0101;
   localparam logic [3:0] DirRev  = 4'b1010;
   localparam logic [3:0] DirTurn = 4'b1001;  // A forward, B reverse: pivot right

   function automatic logic [3:0] dir_of(state_e s);
      case (s)
         StFwd:   return DirFwd;
         StRev:   return DirRev;
         StTurn:  return DirTurn;
         default: return DirStop;
      endcase
   endfunction

   function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rover_pwm.sv
// Free-running PWM: counter 0..PWM_PERIOD-1, registered output high while cnt < duty.
// duty >= PWM_PERIOD gives constant on, duty 0 constant off.
module rover_pwm #(
   parameter int unsigned PWM_PERIOD = 5000,
   parameter int unsigned DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm_o
);

   logic [DUTY_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + DUTY_W'(1);
      if (cnt_q == DUTY_W'(PWM_PERIOD - 1)) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         pwm_o <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_o <= (cnt_q < duty);
      end
   end

endmodule

// File: rtl/obstacle_avoid_ctrl.sv
// Obstacle-avoidance motor controller: synchronizes and debounces the proximity flag, then
// sequences FWD -> BRAKE -> REV -> BRAKE -> TURN -> FWD on the L298 bridge.
module obstacle_avoid_ctrl
   import rover_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned DEBOUNCE_CYC = CLK_HZ / 200,
   parameter int unsigned STOP_CYC     = CLK_HZ / 10,
   parameter int unsigned REVERSE_CYC  = CLK_HZ / 2,
   parameter int unsigned TURN_CYC     = (CLK_HZ / 10) * 4,
   parameter int unsigned PWM_PERIOD   = CLK_HZ / 20_000,
   parameter int unsigned DUTY_FWD     = (PWM_PERIOD * 3) / 4,
   parameter int unsigned DUTY_TURN    = PWM_PERIOD / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       prox_near,
   output logic [3:0] motor_in,
   output logic [1:0] motor_en,
   output logic [2:0] state_o,
   output logic       near_db
);

   localparam int unsigned DwellW = $clog2(max3(STOP_CYC, REVERSE_CYC, TURN_CYC)) + 1;
   localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned DutyW  = $clog2(max3(PWM_PERIOD, DUTY_FWD, DUTY_TURN) + 1);

   // Synchronizer and debouncer
   logic [1:0]     sync_q;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;
   logic           near_db_q, near_db_d;

   always_comb begin
      db_cnt_d  = '0;
      near_db_d = near_db_q;
      if (sync_q[1] != near_db_q) begin
         if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) near_db_d = sync_q[1];
         else                                    db_cnt_d  = db_cnt_q + DbW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 2'b00;
         db_cnt_q  <= '0;
         near_db_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], prox_near};
         db_cnt_q  <= db_cnt_d;
         near_db_q <= near_db_d;
      end
   end

   // FSM; after_q holds where BRAKE goes once its dwell expires
   state_e            state_q, state_d, after_q, after_d;
   logic [DwellW-1:0] dwell_q, dwell_d;
   logic [3:0]        motor_in_q, dir_d;
   logic [DutyW-1:0]  duty;
   logic              pwm;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         after_q    <= StRev;
         dwell_q    <= '0;
         motor_in_q <= DirStop;
      end else begin
         state_q    <= state_d;
         after_q    <= after_d;
         dwell_q    <= dwell_d;
         motor_in_q <= dir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      after_d = after_q;
      dwell_d = dwell_q + DwellW'(1);
      case (state_q)
         StIdle: if (!near_db_q) state_d = StFwd;
         StFwd: begin
            if (near_db_q) begin
               state_d = StBrake;
               after_d = StRev;
            end
         end
         StBrake: if (dwell_q == DwellW'(STOP_CYC - 1)) state_d = after_q;
         StRev: begin
            if (dwell_q == DwellW'(REVERSE_CYC - 1)) begin
               state_d = StBrake;
               after_d = StTurn;
            end
         end
         StTurn: begin
            // Only place a fresh obstacle is honoured outside FWD
            if (dwell_q == DwellW'(TURN_CYC - 1)) begin
               if (!near_db_q) state_d = StFwd;
               else            dwell_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      if (!enable) state_d = StIdle;
      if (state_d != state_q || state_d == StIdle || state_d == StFwd) dwell_d = '0;
   end

   // Outputs follow the next state so bridge, PWM and state code change on the same edge
   always_comb begin
      dir_d = dir_of(state_d);
      case (state_d)
         StFwd, StRev: duty = DutyW'(DUTY_FWD);
         StTurn:       duty = DutyW'(DUTY_TURN);
         default:      duty = '0;
      endcase
   end

   rover_pwm #(
      .PWM_PERIOD (PWM_PERIOD),
      .DUTY_W     (DutyW)
   ) u_pwm (
      .clk   (clk),
      .rst   (rst),
      .duty  (duty),
      .pwm_o (pwm)
   );

   assign motor_in = motor_in_q;
   assign motor_en = {2{pwm}};
   assign state_o  = state_q;
   assign near_db  = near_db_q;

endmodule
